// File: rtl/pong_game_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_game_ctrl_if : frame/collision inputs and ball/score outputs of the
//                     Pong game sequencer.            Rev 1.0
// ---------------------------------------------------------------------------
interface pong_game_ctrl_if;
  logic       i_frame_tick;
  logic       i_start;
  logic       i_collision;
  logic [9:0] o_ball_posx;
  logic [9:0] o_ball_posy;
  logic       o_ball_x_vel;
  logic       o_ball_y_vel;
  logic [3:0] o_p1_score;
  logic [3:0] o_cpu_score;
  logic [2:0] o_state;
  logic       o_point_p1;
  logic       o_point_cpu;
  logic       o_game_over;

  modport master (
    output i_frame_tick, i_start, i_collision,
    input  o_ball_posx, o_ball_posy, o_ball_x_vel, o_ball_y_vel,
           o_p1_score, o_cpu_score, o_state, o_point_p1, o_point_cpu, o_game_over
  );

  modport slave (
    input  i_frame_tick, i_start, i_collision,
    output o_ball_posx, o_ball_posy, o_ball_x_vel, o_ball_y_vel,
           o_p1_score, o_cpu_score, o_state, o_point_p1, o_point_cpu, o_game_over
  );
endinterface
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_game_ctrl : serve/play/point/over sequencer owning ball motion & score.
//                                                      Rev 1.0
// ---------------------------------------------------------------------------
module pong_game_ctrl #(
  parameter int unsigned STEP_X      = 2,
  parameter int unsigned STEP_Y      = 2,
  parameter int unsigned X_MIN       = 0,
  parameter int unsigned X_MAX       = 630,
  parameter int unsigned Y_MIN       = 0,
  parameter int unsigned Y_MAX       = 470,
  parameter int unsigned SERVE_X     = 320,
  parameter int unsigned SERVE_Y     = 240,
  parameter int unsigned SERVE_DELAY = 60,
  parameter int unsigned WIN_SCORE   = 7
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pong_game_ctrl_if.slave  bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic [9:0] c_step_x     = 10'(STEP_X);
  localparam logic [9:0] c_step_y     = 10'(STEP_Y);
  localparam logic [9:0] c_x_lo       = 10'(X_MIN + STEP_X);
  localparam logic [9:0] c_x_hi       = 10'(X_MAX - STEP_X);
  localparam logic [9:0] c_y_lo_lim   = 10'(Y_MIN + STEP_Y);
  localparam logic [9:0] c_y_min      = 10'(Y_MIN);
  localparam logic [9:0] c_y_max      = 10'(Y_MAX);
  localparam logic [9:0] c_serve_x    = 10'(SERVE_X);
  localparam logic [9:0] c_serve_y    = 10'(SERVE_Y);
  localparam logic [7:0] c_serve_last = 8'(SERVE_DELAY - 1);
  localparam logic [3:0] c_win        = 4'(WIN_SCORE);

  logic [2:0] r_state;
  logic [9:0] r_posx;
  logic [9:0] r_posy;
  logic       r_xvel;
  logic       r_yvel;
  logic [3:0] r_p1;
  logic [3:0] r_cpu;
  logic       r_pt_p1;
  logic       r_pt_cpu;
  logic       r_hit;
  logic       r_scorer_cpu;
  logic [7:0] r_cnt;

  logic       w_hit;
  logic [9:0] w_posy_nxt;
  logic       w_yvel_nxt;
  logic [3:0] w_score_nxt;

  // A collision arriving in the same cycle as the tick still counts as a hit
  assign w_hit       = r_hit | bus.i_collision;
  assign w_score_nxt = (r_scorer_cpu ? r_cpu : r_p1) + 4'd1;

  always_comb begin
    w_posy_nxt = r_posy;
    w_yvel_nxt = r_yvel;
    if (r_yvel && (r_posy + c_step_y >= c_y_max)) begin
      w_posy_nxt = c_y_max;
      w_yvel_nxt = 1'b0;
    end else if (!r_yvel && (r_posy <= c_y_lo_lim)) begin
      w_posy_nxt = c_y_min;
      w_yvel_nxt = 1'b1;
    end else if (r_yvel) begin
      w_posy_nxt = r_posy + c_step_y;
    end else begin
      w_posy_nxt = r_posy - c_step_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_posx       <= c_serve_x;
      r_posy       <= c_serve_y;
      r_xvel       <= 1'b0;
      r_yvel       <= 1'b1;
      r_p1         <= 4'd0;
      r_cpu        <= 4'd0;
      r_pt_p1      <= 1'b0;
      r_pt_cpu     <= 1'b0;
      r_hit        <= 1'b0;
      r_scorer_cpu <= 1'b0;
      r_cnt        <= 8'd0;
    end else begin
      r_pt_p1  <= 1'b0;
      r_pt_cpu <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_state <= ST_SERVE;
            r_cnt   <= 8'd0;
          end
        end
        ST_SERVE: begin
          if (bus.i_frame_tick) begin
            if (r_cnt == c_serve_last) r_state <= ST_PLAY;
            else                       r_cnt   <= r_cnt + 8'd1;
          end
        end
        ST_PLAY: begin
          if (bus.i_frame_tick) begin
            r_hit <= 1'b0;
            if (w_hit) begin
              r_xvel <= ~r_xvel;
              r_posx <= r_xvel ? (r_posx - c_step_x) : (r_posx + c_step_x);
              r_posy <= w_posy_nxt;
              r_yvel <= w_yvel_nxt;
            end else if (!r_xvel && (r_posx <= c_x_lo)) begin
              r_scorer_cpu <= 1'b1;
              r_state      <= ST_POINT;
            end else if (r_xvel && (r_posx >= c_x_hi)) begin
              r_scorer_cpu <= 1'b0;
              r_state      <= ST_POINT;
            end else begin
              r_posx <= r_xvel ? (r_posx + c_step_x) : (r_posx - c_step_x);
              r_posy <= w_posy_nxt;
              r_yvel <= w_yvel_nxt;
            end
          end else if (bus.i_collision) begin
            r_hit <= 1'b1;
          end
        end
        ST_POINT: begin
          // Next serve heads toward whoever lost the point
          if (r_scorer_cpu) begin
            r_cpu    <= w_score_nxt;
            r_pt_cpu <= 1'b1;
            r_xvel   <= 1'b0;
          end else begin
            r_p1    <= w_score_nxt;
            r_pt_p1 <= 1'b1;
            r_xvel  <= 1'b1;
          end
          r_yvel  <= ~r_yvel;
          r_posx  <= c_serve_x;
          r_posy  <= c_serve_y;
          r_cnt   <= 8'd0;
          r_state <= (w_score_nxt == c_win) ? ST_OVER : ST_SERVE;
        end
        ST_OVER: begin
          if (bus.i_start) begin
            r_p1    <= 4'd0;
            r_cpu   <= 4'd0;
            r_cnt   <= 8'd0;
            r_state <= ST_SERVE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ball_posx  = r_posx;
  assign bus.o_ball_posy  = r_posy;
  assign bus.o_ball_x_vel = r_xvel;
  assign bus.o_ball_y_vel = r_yvel;
  assign bus.o_p1_score   = r_p1;
  assign bus.o_cpu_score  = r_cpu;
  assign bus.o_state      = r_state;
  assign bus.o_point_p1   = r_pt_p1;
  assign bus.o_point_cpu  = r_pt_cpu;
  assign bus.o_game_over  = (r_state == ST_OVER);

endmodule
`default_nettype wire
